// File: rtl/oric_mem_pkg.sv
// rtl/oric_mem_pkg.sv - shared types for the main-RAM port sequencer
package oric_mem_pkg;

    localparam int MAX_AW = 16;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CPU,
        SRC_TAPE,
        SRC_CLEAR
    } ram_src_e;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } seq_state_e;

    typedef struct packed {
        logic [MAX_AW-1:0] addr;
        logic [7:0]        data;
    } tape_wr_t;

endpackage

// File: rtl/oric_sync_fifo.sv
// rtl/oric_sync_fifo.sv - show-ahead synchronous FIFO with registered full flag
module oric_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    // A push while full is accepted only when the same cycle frees a slot.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        full_d   = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/oric_ram_sequencer.sv
// rtl/oric_ram_sequencer.sv - shares the main RAM port between clear engine, CPU and tape loader
module oric_ram_sequencer
    import oric_mem_pkg::*;
#(
    parameter int         AW             = 16,
    parameter logic [7:0] CLEAR_VAL      = 8'h01,
    parameter int         FIFO_DEPTH     = 4,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          clear_req,
    output logic          clear_busy,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_ad,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    output logic          cpu_q_valid,
    input  logic          tape_wr,
    input  logic [AW-1:0] tape_addr,
    input  logic [7:0]    tape_dout,
    output logic          tape_full,
    output logic          tape_ovf,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_ad,
    output logic [7:0]    ram_d,
    input  logic [7:0]    ram_q
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int TW = $bits(tape_wr_t);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          start_q, start_d;
    logic          ram_cs_q, ram_cs_d, ram_we_q, ram_we_d;
    logic [AW-1:0] ram_ad_q, ram_ad_d;
    logic [7:0]    ram_d_q, ram_d_d;
    logic          rd1_q, rd1_d, rd2_q, rd2_d, q_valid_q, q_valid_d;
    logic [7:0]    cpu_q_q, cpu_q_d;
    logic          ovf_q, ovf_d;

    ram_src_e      src;
    logic          clear_active, pop, drop;
    logic [AW-1:0] clr_ad;
    tape_wr_t      tw_in, tw_head;
    logic [TW-1:0] fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    oric_sync_fifo #(.WIDTH(TW), .DEPTH(FIFO_DEPTH)) u_tape_fifo (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .push    (tape_wr),
        .din     (tw_in),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        tw_in      = '0;
        tw_in.addr = MAX_AW'(tape_addr);
        tw_in.data = tape_dout;
        tw_head    = tape_wr_t'(fifo_dout);

        // clear_req takes effect in its own cycle: the write it grants goes to address 0.
        clear_active = (state_q == ST_CLEAR) || clear_req;
        clr_ad       = clear_req ? '0 : cnt_q;

        if (clear_active)     src = SRC_CLEAR;
        else if (cpu_cs)      src = SRC_CPU;
        else if (!fifo_empty) src = SRC_TAPE;
        else                  src = SRC_NONE;

        pop  = (src == SRC_TAPE);
        drop = tape_wr && (fifo_count == CW'(FIFO_DEPTH)) && !pop;

        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        if (start_q) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end
        if (clear_active) begin
            cnt_d   = clr_ad + AW'(1);
            state_d = (&clr_ad) ? ST_IDLE : ST_CLEAR;
        end

        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        ram_ad_d = '0;
        ram_d_d  = '0;
        case (src)
            SRC_CLEAR: begin
                ram_cs_d = 1'b1;
                ram_we_d = 1'b1;
                ram_ad_d = clr_ad;
                ram_d_d  = CLEAR_VAL;
            end
            SRC_CPU: begin
                ram_cs_d = 1'b1;
                ram_we_d = cpu_we;
                ram_ad_d = cpu_ad;
                ram_d_d  = cpu_d;
            end
            SRC_TAPE: begin
                ram_cs_d = 1'b1;
                ram_we_d = 1'b1;
                ram_ad_d = tw_head.addr[AW-1:0];
                ram_d_d  = tw_head.data;
            end
            default: ;
        endcase

        rd1_d     = (src == SRC_CPU) && !cpu_we;
        rd2_d     = rd1_q;
        q_valid_d = rd2_q;
        cpu_q_d   = rd2_q ? ram_q : cpu_q_q;
        ovf_d     = clear_req ? 1'b0 : (ovf_q | drop);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            start_q   <= CLEAR_ON_RESET;
            ram_cs_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            ram_ad_q  <= '0;
            ram_d_q   <= '0;
            rd1_q     <= 1'b0;
            rd2_q     <= 1'b0;
            q_valid_q <= 1'b0;
            cpu_q_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            ram_cs_q  <= ram_cs_d;
            ram_we_q  <= ram_we_d;
            ram_ad_q  <= ram_ad_d;
            ram_d_q   <= ram_d_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            q_valid_q <= q_valid_d;
            cpu_q_q   <= cpu_q_d;
            ovf_q     <= ovf_d;
        end
    end

    assign clear_busy  = (state_q == ST_CLEAR);
    assign cpu_q       = cpu_q_q;
    assign cpu_q_valid = q_valid_q;
    assign tape_full   = fifo_full;
    assign tape_ovf    = ovf_q;
    assign ram_cs      = ram_cs_q;
    assign ram_we      = ram_we_q;
    assign ram_ad      = ram_ad_q;
    assign ram_d       = ram_d_q;

endmodule
